// File: rtl/key_device_pkg.sv
// Shared constants for the KEY bus device: register addresses and KCTRL bit layout.
// Kept separate so the SW device and the top-level bus mux can reuse the same map.
package key_device_pkg;

   localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;
   localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;

   localparam int CTRL_READY   = 0;
   localparam int CTRL_OVERRUN = 2;
   localparam int CTRL_IE      = 8;

   typedef struct packed {
      logic ie;
      logic overrun;
      logic ready;
   } ctrl_t;

   function automatic logic [31:0] pack_ctrl(input ctrl_t c);
      logic [31:0] w;
      w               = '0;
      w[CTRL_READY]   = c.ready;
      w[CTRL_OVERRUN] = c.overrun;
      w[CTRL_IE]      = c.ie;
      return w;
   endfunction

endpackage

// File: rtl/key_device_debouncer.sv
// Synchronises and debounces asynchronous pins into a stable value plus an accept pulse.
// Latency: 2 sync edges + DEBOUNCE_CYCLES stable edges; evt is combinational for the accept edge.
// No backpressure: evt is a single-cycle strobe that the consumer must take on that edge.
module key_device_debouncer #(
   parameter int KBITS           = 4,
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int CNT_BITS        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [KBITS-1:0] key,
   output logic [KBITS-1:0] kdata,
   output logic             evt
);

   localparam logic [CNT_BITS-1:0] CNT_TARGET = CNT_BITS'(DEBOUNCE_CYCLES);

   logic [KBITS-1:0]    sync1;
   logic [KBITS-1:0]    ksync;
   logic [KBITS-1:0]    kprev;
   logic [CNT_BITS-1:0] cnt;
   logic [CNT_BITS-1:0] cnt_nxt;

   // Any change in the synced value restarts the run so only a steady level is accepted.
   always_comb begin
      cnt_nxt = '0;
      if (ksync == kdata)
         cnt_nxt = '0;
      else if (ksync != kprev)
         cnt_nxt = CNT_BITS'(1);
      else
         cnt_nxt = cnt + 1'b1;
   end

   assign evt = (ksync != kdata) && (cnt_nxt == CNT_TARGET);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '1;
         ksync <= '1;
         kprev <= '1;
         kdata <= '1;
         cnt   <= '0;
      end else begin
         sync1 <= key;
         ksync <= sync1;
         kprev <= ksync;
         if (evt) begin
            kdata <= ksync;
            cnt   <= '0;
         end else begin
            cnt <= cnt_nxt;
         end
      end
   end

endmodule

// File: rtl/key_device.sv
// Memory-mapped KEY responder: KDATA/KCTRL registers, ready/overrun status, registered interrupt.
// Latency: dOut is combinational from addr; side effects and intr update on the clk edge.
// No backpressure: every load/store strobe is accepted in its cycle.
module key_device
   import key_device_pkg::*;
#(
   parameter int DBITS           = 32,
   parameter int KBITS           = 4,
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int CNT_BITS        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [KBITS-1:0] key,
   input  logic [DBITS-1:0] addr,
   input  logic             rdEn,
   input  logic             wrtEn,
   input  logic [DBITS-1:0] dIn,
   output logic [DBITS-1:0] dOut,
   output logic             hit,
   output logic             intr
);

   logic [KBITS-1:0] kdata;
   logic             key_evt;
   ctrl_t            ctrl;
   logic             hit_kdata;
   logic             hit_kctrl;
   logic             rd_kdata;
   logic             wr_kctrl;
   logic             unused_din;

   key_device_debouncer #(
      .KBITS           (KBITS),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_BITS        (CNT_BITS)
   ) u_debouncer (
      .clk   (clk),
      .reset (reset),
      .key   (key),
      .kdata (kdata),
      .evt   (key_evt)
   );

   assign hit_kdata = (addr == DBITS'(ADDR_KDATA));
   assign hit_kctrl = (addr == DBITS'(ADDR_KCTRL));
   assign hit       = hit_kdata | hit_kctrl;
   assign rd_kdata  = rdEn & hit_kdata;
   assign wr_kctrl  = wrtEn & hit_kctrl;

   assign unused_din = ^{dIn[DBITS-1:CTRL_IE+1], dIn[CTRL_IE-1:CTRL_OVERRUN+1],
                         dIn[CTRL_OVERRUN-1:0]};

   always_comb begin
      dOut = '0;
      if (hit_kdata)
         dOut[KBITS-1:0] = kdata;
      else if (hit_kctrl)
         dOut = DBITS'(pack_ctrl(ctrl));
   end

   // A new value always wins over a concurrent clear, so software never loses an event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl <= '0;
         intr <= 1'b0;
      end else begin
         if (key_evt)
            ctrl.ready <= 1'b1;
         else if (rd_kdata)
            ctrl.ready <= 1'b0;

         if (key_evt && ctrl.ready && !rd_kdata)
            ctrl.overrun <= 1'b1;
         else if (wr_kctrl && !dIn[CTRL_OVERRUN])
            ctrl.overrun <= 1'b0;

         if (wr_kctrl)
            ctrl.ie <= dIn[CTRL_IE];

         intr <= ctrl.ready & ctrl.ie;
      end
   end

endmodule

// File: tb/tb_key_device.sv
// Self-checking bench for key_device with a short debounce window; expected read data goes
// through a scoreboard queue pushed at stimulus time and popped when the DUT output is sampled.
module tb_key_device;
   import key_device_pkg::*;

   localparam int DBITS = 32;
   localparam int KBITS = 4;
   localparam int DEB   = 4;
   localparam logic [31:0] ADDR_OTHER = 32'hF000_0014;

   logic             clk = 1'b0;
   logic             reset;
   logic [KBITS-1:0] key;
   logic [DBITS-1:0] addr;
   logic             rdEn;
   logic             wrtEn;
   logic [DBITS-1:0] dIn;
   logic [DBITS-1:0] dOut;
   logic             hit;
   logic             intr;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] got;
   logic [31:0] exp;
   logic        got_hit;

   always #5 clk = ~clk;

   key_device #(
      .DBITS           (DBITS),
      .KBITS           (KBITS),
      .DEBOUNCE_CYCLES (DEB),
      .CNT_BITS        (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .key   (key),
      .addr  (addr),
      .rdEn  (rdEn),
      .wrtEn (wrtEn),
      .dIn   (dIn),
      .dOut  (dOut),
      .hit   (hit),
      .intr  (intr)
   );

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Observe a register without a load strobe, so no read side effect occurs.
   task automatic peek(input logic [31:0] a, output logic [31:0] d, output logic h);
      addr = a;
      #1;
      d = dOut;
      h = hit;
      addr = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
      addr = a;
      rdEn = 1'b1;
      #1;
      d = dOut;
      h = hit;
      @(posedge clk);
      #1;
      rdEn = 1'b0;
      addr = '0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      dIn   = d;
      wrtEn = 1'b1;
      @(posedge clk);
      #1;
      wrtEn = 1'b0;
      dIn   = '0;
      addr  = '0;
   endtask

   task automatic apply_reset;
      reset = 1'b1;
      key   = 4'hF;
      addr  = '0;
      rdEn  = 1'b0;
      wrtEn = 1'b0;
      dIn   = '0;
      edges(2);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      apply_reset();
      total++; if (intr !== 1'b0) begin bad++; $display("FAIL reset_intr got=%b exp=0", intr); end
      exp_q.push_back(32'h0000_000F);
      bus_read(ADDR_KDATA, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL reset_kdata got=%h exp=%h", got, exp); end
      total++; if (got_hit !== 1'b1) begin bad++; $display("FAIL reset_kdata_hit got=%b exp=1", got_hit); end
      exp_q.push_back(32'h0);
      bus_read(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL reset_kctrl got=%h exp=%h", got, exp); end
      total++; if (got_hit !== 1'b1) begin bad++; $display("FAIL reset_kctrl_hit got=%b exp=1", got_hit); end
      // Off-window store must not touch KCTRL.
      bus_write(ADDR_OTHER, 32'h104);
      peek(ADDR_OTHER, got, got_hit);
      total++; if (got_hit !== 1'b0 || got !== 32'h0) begin bad++; $display("FAIL other_addr got=%h hit=%b exp=0 hit=0", got, got_hit); end
      exp_q.push_back(32'h0);
      peek(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL other_write_kctrl got=%h exp=%h", got, exp); end
   endtask

   task automatic test_press;
      apply_reset();
      key = 4'hE;
      edges(DEB + 1);
      exp_q.push_back(32'h0);
      peek(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL press_early_ready got=%h exp=%h", got, exp); end
      edges(1);
      exp_q.push_back(32'h1);
      peek(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL press_ready got=%h exp=%h", got, exp); end
      exp_q.push_back(32'hE);
      bus_read(ADDR_KDATA, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL press_kdata got=%h exp=%h", got, exp); end
      exp_q.push_back(32'h0);
      peek(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL press_ready_clear got=%h exp=%h", got, exp); end
   endtask

   task automatic test_bounce;
      int seen_ready;
      apply_reset();
      seen_ready = 0;
      for (int i = 0; i < 30; i++) begin
         if (i % 3 == 0) key[0] = ~key[0];
         edges(1);
         peek(ADDR_KCTRL, got, got_hit);
         if (got[CTRL_READY]) seen_ready++;
      end
      key = 4'hF;
      edges(DEB + 4);
      total++; if (seen_ready !== 0) begin bad++; $display("FAIL bounce_ready_cycles got=%0d exp=0", seen_ready); end
      exp_q.push_back(32'h0);
      peek(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL bounce_kctrl got=%h exp=%h", got, exp); end
      exp_q.push_back(32'hF);
      peek(ADDR_KDATA, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL bounce_kdata got=%h exp=%h", got, exp); end
   endtask

   task automatic test_irq;
      apply_reset();
      bus_write(ADDR_KCTRL, 32'h100);
      key = 4'hE;
      edges(DEB + 2);
      total++; if (intr !== 1'b0) begin bad++; $display("FAIL irq_same_edge got=%b exp=0", intr); end
      edges(1);
      total++; if (intr !== 1'b1) begin bad++; $display("FAIL irq_assert got=%b exp=1", intr); end
      exp_q.push_back(32'h101);
      peek(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL irq_kctrl got=%h exp=%h", got, exp); end
      bus_read(ADDR_KDATA, got, got_hit);
      total++; if (intr !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b exp=1", intr); end
      edges(1);
      total++; if (intr !== 1'b0) begin bad++; $display("FAIL irq_deassert got=%b exp=0", intr); end
   endtask

   task automatic test_overrun;
      apply_reset();
      key = 4'hE;
      edges(DEB + 2);
      key = 4'hF;
      edges(DEB + 2);
      exp_q.push_back(32'h5);
      peek(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL overrun_set got=%h exp=%h", got, exp); end
      exp_q.push_back(32'hF);
      peek(ADDR_KDATA, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL overrun_kdata got=%h exp=%h", got, exp); end
      bus_write(ADDR_KCTRL, 32'h0);
      exp_q.push_back(32'h1);
      peek(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL overrun_clear got=%h exp=%h", got, exp); end
      bus_write(ADDR_KCTRL, 32'h4);
      exp_q.push_back(32'h1);
      peek(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL overrun_write1 got=%h exp=%h", got, exp); end
   endtask

   task automatic test_back_to_back;
      apply_reset();
      key = 4'hE;
      edges(DEB + 1);
      // Load straddles the accept edge: old value returned, ready survives.
      exp_q.push_back(32'hF);
      bus_read(ADDR_KDATA, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL coinc_read_old got=%h exp=%h", got, exp); end
      exp_q.push_back(32'h1);
      peek(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL coinc_read_status got=%h exp=%h", got, exp); end
      exp_q.push_back(32'hE);
      peek(ADDR_KDATA, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL coinc_read_kdata got=%h exp=%h", got, exp); end
      // Overrun clear straddles the next accept edge: the set wins.
      key = 4'hF;
      edges(DEB + 1);
      bus_write(ADDR_KCTRL, 32'h0);
      exp_q.push_back(32'h5);
      peek(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL coinc_write_overrun got=%h exp=%h", got, exp); end
      // Simultaneous load and store on KCTRL.
      addr  = ADDR_KCTRL;
      rdEn  = 1'b1;
      wrtEn = 1'b1;
      dIn   = 32'h104;
      exp_q.push_back(32'h5);
      #1;
      got = dOut;
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL rdwr_read got=%h exp=%h", got, exp); end
      edges(1);
      rdEn  = 1'b0;
      wrtEn = 1'b0;
      dIn   = '0;
      exp_q.push_back(32'h105);
      peek(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL rdwr_after got=%h exp=%h", got, exp); end
   endtask

   task automatic test_reset_mid;
      apply_reset();
      key = 4'hE;
      edges(DEB + 2);
      key = 4'hF;
      edges(DEB + 2);
      bus_write(ADDR_KCTRL, 32'h100);
      edges(1);
      total++; if (intr !== 1'b1) begin bad++; $display("FAIL rmid_intr_before got=%b exp=1", intr); end
      key = 4'hE;
      edges(4);
      reset = 1'b1;
      #1;
      exp_q.push_back(32'h0);
      peek(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL rmid_kctrl got=%h exp=%h", got, exp); end
      total++; if (intr !== 1'b0) begin bad++; $display("FAIL rmid_intr got=%b exp=0", intr); end
      exp_q.push_back(32'hF);
      peek(ADDR_KDATA, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL rmid_kdata got=%h exp=%h", got, exp); end
      edges(2);
      reset = 1'b0;
      edges(DEB + 1);
      exp_q.push_back(32'h0);
      peek(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL rmid_early got=%h exp=%h", got, exp); end
      edges(1);
      exp_q.push_back(32'h1);
      peek(ADDR_KCTRL, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL rmid_event got=%h exp=%h", got, exp); end
      exp_q.push_back(32'hE);
      peek(ADDR_KDATA, got, got_hit);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL rmid_kdata_after got=%h exp=%h", got, exp); end
   endtask

   initial begin
      reset = 1'b1;
      key   = 4'hF;
      addr  = '0;
      rdEn  = 1'b0;
      wrtEn = 1'b0;
      dIn   = '0;
      test_reset();
      test_press();
      test_bounce();
      test_irq();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_device.md
Name: key_device

Overview:
- Memory-mapped responder for the processor's data-memory bus; serves loads and stores targeting the KEY address window.
- Synchronises and debounces the raw KEY pins, and latches a new debounced value as a data event.
- Exposes a data register and a control/status register with ready, overrun and interrupt-enable bits.
- Drives an interrupt request line; sits beside DataMemory, and the top level muxes its read data when hit is asserted.

Parameters:
- DBITS, 32, bus data and address width
- KBITS, 4, number of key inputs
- ADDR_KDATA, 32'hF0000010, address of the key data register
- ADDR_KCTRL, 32'hF0000110, address of the control/status register
- DEBOUNCE_CYCLES, 10000, consecutive stable cycles required before a new value is accepted (minimum 1)
- CNT_BITS, 16, debounce counter width; must satisfy 2^CNT_BITS > DEBOUNCE_CYCLES

Ports:
- clk  input  1  system clock; the only clock
- reset  input  1  asynchronous, active-high reset
- key  input  KBITS  raw KEY pins, asynchronous to clk, idle-high
- addr  input  DBITS  bus address
- rdEn  input  1  load strobe, one cycle per access
- wrtEn  input  1  store strobe, one cycle per access
- dIn  input  DBITS  store data
- dOut  output  DBITS  load data; 0 when hit is low
- hit  output  1  addr equals ADDR_KDATA or ADDR_KCTRL
- intr  output  1  interrupt request

Behaviour:
- Reset (async, active-high):
  - sync stages, stable register (kdata) and last-sample register all cleared to all-ones
  - debounce counter = 0
  - ready, overrun, ie = 0
  - intr = 0; dOut is combinational, 0 unless hit
- Synchroniser: 2-flop chain on key. Synced value ksync is valid 2 clk edges after a pin change.
- Debounce:
  - If ksync == kdata, the counter clears to 0.
  - Otherwise, if ksync differs from the previous-cycle ksync, the counter restarts at 1.
  - Otherwise the counter increments by 1.
  - When the counter reaches DEBOUNCE_CYCLES, kdata <= ksync, the counter clears, and a one-cycle event pulse fires on the same edge.
  - A bounce shorter than DEBOUNCE_CYCLES never updates kdata.
- Register map:
  - KDATA, read-only: bits KBITS-1:0 = kdata; upper bits 0. Writes are ignored.
  - KCTRL:
    - bit0 ready (read-only)
    - bit2 overrun: write 0 clears, write 1 ignored
    - bit8 ie: read/write
    - all other bits read 0 and ignore writes
- Reads:
  - dOut is combinational from addr (zero-latency, matching DataMemory).
  - Side effects take place on the clk edge where rdEn && hit.
  - A KDATA read clears ready at that edge. A KCTRL read has no side effect.
- Event handling:
  - On event: ready <= 1; if ready was already 1 and is not being cleared by a KDATA read this edge, overrun <= 1.
  - Event coincident with a KDATA read: the read returns the old kdata, ready stays 1, overrun is unchanged.
  - Event coincident with a KCTRL write of overrun=0: the set wins, so overrun = 1 if the overrun condition holds.
  - rdEn and wrtEn asserted together: both are honoured independently.
  - Accesses to other addresses: hit = 0, no state change.
- intr = ready & ie, registered: asserts 1 cycle after both bits are 1 and deasserts 1 cycle after either clears.
- Reset mid-debounce discards the partial count. Reset after a sampled press with key still held low: a new debounce run begins and an event fires DEBOUNCE_CYCLES+2 cycles after reset deasserts.

Decomposition:
- Shared package:
  - address constants ADDR_KDATA and ADDR_KCTRL
  - KCTRL bit positions: CTRL_READY=0, CTRL_OVERRUN=2, CTRL_IE=8
- One natural sub-module: debouncer (synchroniser, counter and stable register; outputs kdata and an event pulse), reusable for the SW device.
- The bus decode and status logic stay in key_device.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
- Reset, then read KDATA and KCTRL -> dOut = 32'h0000000F, then 32'h0; intr = 0; hit = 1 on both reads.
- Drive key=4'b1110 and hold -> kdata = 4'hE and ready = 1 exactly 6 edges after the change (2 sync + 4 debounce); read KDATA -> 32'hE and ready clears next edge.
- Toggle key[0] every 3 cycles for 30 cycles, then restore 4'hF -> no event, ready stays 0, kdata stays 4'hF.
- Write KCTRL = 32'h100, then make a debounced press -> intr = 1 one cycle after ready sets; read KDATA -> intr = 0 one cycle after ready clears.
- Two debounced changes (4'hE, then 4'hF) with no read in between -> KCTRL reads 32'h5. Write KCTRL = 32'h0 -> 32'h1. Write KCTRL = 32'h4 -> overrun stays 0.
- Event edge coincident with a KDATA read -> read returns the prior value, ready = 1, overrun = 0. Assert reset mid-count -> counter, ready and overrun all cleared immediately without waiting for a clk edge.
